trace_stream_receiver: RTL and testbench

// AXI-Stream slave that consumes {pc, instr} trace beats from the monitoring

---
 rtl/trace_stream_receiver_if.sv | 13 +
 rtl/trace_stream_receiver.sv | 175 +++++++++++++++++
 tb/tb_trace_stream_receiver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_stream_receiver_if.sv
// AXI-Stream beat channel carrying {pc, instr} trace beats into the receiver.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both high.
interface trace_stream_receiver_if #(
    parameter int DATA_W = 96
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/trace_stream_receiver.sv
// Trace stream sink/checker: buffers {pc, instr} beats in a FWFT FIFO and tracks burst spacing, WFI and counts.
// Optional TRACE_RX_STALL_COUNT_EN enables the saturating stall_count statistic.
module trace_stream_receiver #(
    parameter int XLEN           = 64,
    parameter int AXI_DATA_WIDTH = XLEN + 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    trace_stream_receiver_if.slave S_AXIS,
    input  logic [31:0]          tlast_interval,
    input  logic                 clear_stats,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_instr,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] burst_count,
    output logic                 interval_error,
    output logic                 post_wfi_beat,
    output logic                 wfi_seen,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [1:0]           dbg_state
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = AXI_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_BURST = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full, empty, accept, pop;
    logic [ENTRY_W-1:0] head;

    assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty         = (count_q == '0);
    assign S_AXIS.tready = ~full;
    assign accept        = S_AXIS.tvalid & ~full;
    assign pop           = ~empty & out_ready;

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= {S_AXIS.tlast, S_AXIS.tdata};
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    assign head      = empty ? '0 : mem_q[rd_ptr_q];
    assign out_valid = ~empty;
    assign out_last  = head[AXI_DATA_WIDTH];
    assign out_pc    = head[AXI_DATA_WIDTH-1:32];
    assign out_instr = head[31:0];

    state_t               state_q, state_d;
    logic [31:0]          beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, burst_cnt_q, burst_cnt_d;
    logic                 ierr_q, ierr_d, pwfi_q, pwfi_d;
    logic                 is_wfi;
    logic [32:0]          idx_plus1;

    assign is_wfi    = (S_AXIS.tdata[31:0] == 32'h0000_0001);
    assign idx_plus1 = {1'b0, beat_idx_q} + 33'd1;

    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        ierr_d      = ierr_q;
        pwfi_d      = pwfi_q;
        if (clear_stats) begin
            state_d     = ST_IDLE;
            beat_idx_d  = '0;
            beat_cnt_d  = '0;
            burst_cnt_d = '0;
            ierr_d      = 1'b0;
            pwfi_d      = 1'b0;
        end else if (accept) begin
            beat_cnt_d = sat_inc(beat_cnt_q);
            if (S_AXIS.tlast) burst_cnt_d = sat_inc(burst_cnt_q);
            if (state_q == ST_DONE) pwfi_d = 1'b1;
            beat_idx_d = S_AXIS.tlast ? '0 :
                         ((beat_idx_q == '1) ? beat_idx_q : beat_idx_q + 32'd1);
            // A WFI beat may close its burst early, so it is exempt from the spacing check.
            if (tlast_interval != '0 && state_q != ST_DONE && !is_wfi &&
                (( S_AXIS.tlast && idx_plus1 != {1'b0, tlast_interval}) ||
                 (!S_AXIS.tlast && idx_plus1 == {1'b0, tlast_interval})))
                ierr_d = 1'b1;
            if (is_wfi) begin
                state_d = ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_IN_BURST: state_d = S_AXIS.tlast ? ST_IDLE : ST_IN_BURST;
                    default:              state_d = ST_DONE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            ierr_q      <= 1'b0;
            pwfi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            ierr_q      <= ierr_d;
            pwfi_q      <= pwfi_d;
        end
    end

    assign beat_count     = beat_cnt_q;
    assign burst_count    = burst_cnt_q;
    assign interval_error = ierr_q;
    assign post_wfi_beat  = pwfi_q;
    assign wfi_seen       = (state_q == ST_DONE);
    assign dbg_state      = state_q;

`ifdef TRACE_RX_STALL_COUNT_EN
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clear_stats)                stall_d = '0;
        else if (S_AXIS.tvalid && full) stall_d = sat_inc(stall_q);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_trace_stream_receiver.sv
// Directed bench for trace_stream_receiver: a driver pushes expected beats into a queue
// and an independent monitor pops and compares every beat the DUT hands out.
module tb_trace_stream_receiver;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tlast_interval;
    logic        clear_stats;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] beat_count, burst_count, stall_count;
    logic        interval_error, post_wfi_beat, wfi_seen;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int pop_count = 0;
    logic [96:0] exp_q[$];

    trace_stream_receiver_if #(.DATA_W(96)) axis ();

    trace_stream_receiver dut (
        .clk(clk), .rst(rst), .S_AXIS(axis),
        .tlast_interval(tlast_interval), .clear_stats(clear_stats),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_last(out_last), .beat_count(beat_count),
        .burst_count(burst_count), .interval_error(interval_error),
        .post_wfi_beat(post_wfi_beat), .wfi_seen(wfi_seen),
        .stall_count(stall_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h expected none", {out_last, out_pc, out_instr});
            end else begin
                check("sb_data", {out_last, out_pc, out_instr}, exp_q.pop_front());
            end
            pop_count++;
        end
    end

    task automatic send_beat(input logic [63:0] pc, input logic [31:0] instr, input logic last);
        int n = 0;
        axis.tvalid = 1'b1;
        axis.tdata  = {pc, instr};
        axis.tlast  = last;
        @(negedge clk);
        while (!axis.tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!axis.tready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got tready=0 expected 1 for pc %0h", pc);
        end else begin
            exp_q.push_back({last, pc, instr});
        end
        @(posedge clk);
        #1;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", out_valid, 1'b0);
        check("drain_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        tlast_interval = 32'd0;
        clear_stats = 1'b0;
        out_ready = 1'b0;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        axis.tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_tready", axis.tready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_beat_count", beat_count, 0);
        check("rst_burst_count", burst_count, 0);
        check("rst_interval_error", interval_error, 1'b0);
        check("rst_post_wfi", post_wfi_beat, 1'b0);
        check("rst_wfi_seen", wfi_seen, 1'b0);
        check("rst_stall_count", stall_count, 0);
        check("rst_state", dbg_state, 2'd0);

        // Two well-formed bursts of four
        tlast_interval = 32'd4;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send_beat(64'h1000 + 64'(i * 4), 32'h13 + 32'(i * 32'h100), (i == 3 || i == 7));
        wait_drain();
        check("a_beat_count", beat_count, 8);
        check("a_burst_count", burst_count, 2);
        check("a_interval_error", interval_error, 1'b0);
        check("a_state", dbg_state, 2'd0);

        pulse_clear();
        check("clr_beat_count", beat_count, 0);

        // Early tlast on the third beat
        send_beat(64'h1100, 32'h33, 1'b0);
        send_beat(64'h1104, 32'h33, 1'b0);
        check("b_no_err_yet", interval_error, 1'b0);
        send_beat(64'h1108, 32'h33, 1'b1);
        check("b_err_set", interval_error, 1'b1);
        for (int i = 0; i < 4; i++)
            send_beat(64'h1200 + 64'(i * 4), 32'h93, (i == 3));
        check("b_err_sticky", interval_error, 1'b1);
        check("b_burst_count", burst_count, 2);
        check("b_beat_count", beat_count, 7);
        wait_drain();

        // Fill to full with the consumer stalled, then hold a 17th beat
        pulse_clear();
        tlast_interval = 32'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send_beat(64'h2000 + 64'(i * 4), 32'h200 + 32'(i), 1'b0);
        axis.tvalid = 1'b1;
        axis.tdata  = {64'h2040, 32'h210};
        axis.tlast  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("c_full_tready", axis.tready, 1'b0);
        check("c_beat_count", beat_count, 16);
        check("c_head_pc", out_pc, 64'h2000);
`ifdef TRACE_RX_STALL_COUNT_EN
        check("c_stall_count", stall_count, 5);
`else
        check("c_stall_count", stall_count, 0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!axis.tready && n < 50) begin
                n++;
                @(negedge clk);
            end
            check("c_tready_back", axis.tready, 1'b1);
            exp_q.push_back({1'b0, 64'h2040, 32'h210});
            @(posedge clk);
            #1;
            axis.tvalid = 1'b0;
        end
        wait_drain();
        check("c_beat_count17", beat_count, 17);

        // WFI closes the burst early, later beats are flagged
        pulse_clear();
        tlast_interval = 32'd4;
        send_beat(64'h3000, 32'h13, 1'b0);
        send_beat(64'h3004, 32'h1, 1'b1);
        check("d_wfi_seen", wfi_seen, 1'b1);
        check("d_no_err", interval_error, 1'b0);
        check("d_state_done", dbg_state, 2'd2);
        check("d_burst_count", burst_count, 1);
        check("d_post_wfi_clear", post_wfi_beat, 1'b0);
        send_beat(64'h3008, 32'h13, 1'b0);
        check("d_post_wfi", post_wfi_beat, 1'b1);
        check("d_beat_count", beat_count, 3);
        check("d_no_err_done", interval_error, 1'b0);
        wait_drain();
        pulse_clear();
        check("d_clr_wfi", wfi_seen, 1'b0);
        check("d_clr_post_wfi", post_wfi_beat, 1'b0);
        check("d_clr_beats", beat_count, 0);
        check("d_clr_bursts", burst_count, 0);
        check("d_clr_state", dbg_state, 2'd0);

        // Steady push+pop at occupancy 5
        tlast_interval = 32'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_beat(64'h4000 + 64'(i * 4), 32'h400 + 32'(i), 1'b0);
        p0 = pop_count;
        out_ready = 1'b1;
        for (int i = 5; i < 15; i++)
            send_beat(64'h4000 + 64'(i * 4), 32'h400 + 32'(i), 1'b0);
        out_ready = 1'b0;
        check("e_pops_during", pop_count - p0, 10);
        check("e_still_valid", out_valid, 1'b1);
        p0 = pop_count;
        out_ready = 1'b1;
        wait_drain();
        check("e_occupancy", pop_count - p0, 5);

        // Clear coincident with an accepted beat: stats cleared, beat kept
        pulse_clear();
        out_ready = 1'b0;
        clear_stats = 1'b1;
        send_beat(64'h5000, 32'h77, 1'b1);
        clear_stats = 1'b0;
        check("f_beat_count", beat_count, 0);
        check("f_burst_count", burst_count, 0);
        check("f_stored", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a burst with three beats buffered
        out_ready = 1'b0;
        tlast_interval = 32'd4;
        for (int i = 0; i < 3; i++)
            send_beat(64'h6000 + 64'(i * 4), 32'h600, 1'b0);
        check("g_buffered", out_valid, 1'b1);
        check("g_beats", beat_count, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("g_rst_out_valid", out_valid, 1'b0);
        check("g_rst_beats", beat_count, 0);
        check("g_rst_state", dbg_state, 2'd0);
        check("g_rst_tready", axis.tready, 1'b1);
        out_ready = 1'b1;
        send_beat(64'h7000, 32'h700, 1'b0);
        wait_drain();
        check("g_after_beats", beat_count, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
